// File: rtl/c499_lock_pkg.sv
// c499_lock_pkg: shared constants, FSM state codes and the key parity helper for
// the c499 key-load / operand sequencer.
//   DEF_KEY_W    key bits driven onto p1..p28
//   DEF_DIN_W    datapath operand width (N1..N137)
//   DEF_DOUT_W   datapath result width (N724..N755)
//   DEF_MAX_FAIL failed loads before the block locks until reset
package c499_lock_pkg;

  localparam int DEF_KEY_W    = 28;
  localparam int DEF_DIN_W    = 41;
  localparam int DEF_DOUT_W   = 32;
  localparam int DEF_MAX_FAIL = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SHIFT  = 3'd1;
  localparam state_t ST_CHECK  = 3'd2;
  localparam state_t ST_ARMED  = 3'd3;
  localparam state_t ST_ERROR  = 3'd4;
  localparam state_t ST_LOCKED = 3'd5;

  // Even parity bit: the value that makes the total count of ones even.
  // Callers zero-extend the key, which leaves the parity unchanged.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/c499_pipe2.sv
// c499_pipe2: two-stage valid/ready register pair around the external combinational
// c499 datapath. Stage 1 holds the operand (dp_in), stage 2 captures the result.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          new accepts allowed (key armed); in-flight items always drain
//   in_valid/in_ready/in_data   operand handshake
//   dp_in/dp_out                registered operand out, combinational result back
//   out_valid/out_ready/out_data result handshake
//   empty       both stages vacant
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// valid never depends on ready, and a presented result holds until taken.
module c499_pipe2 #(
  parameter int DIN_W  = 41,
  parameter int DOUT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  in_data,
  output logic [DIN_W-1:0]  dp_in,
  input  logic [DOUT_W-1:0] dp_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] out_data,
  output logic              empty
);

  logic s1_v;
  logic s2_v;
  logic accept;
  logic s2_load;

  // Stage 1 frees up whenever its content can move into stage 2 this edge.
  assign in_ready = en & (!s1_v | !s2_v | out_ready);
  assign accept   = in_valid & in_ready;
  assign s2_load  = s1_v & (!s2_v | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      dp_in    <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        s1_v  <= 1'b1;
        dp_in <= in_data;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      if (s2_load) begin
        s2_v     <= 1'b1;
        out_data <= dp_out;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = s2_v;
  assign empty     = !s1_v & !s2_v;

endmodule

// File: rtl/c499_lock_ctrl.sv
// c499_lock_ctrl: serially loads and parity-checks the 28-bit unlock key, drives it
// onto the datapath key pins, and sequences operands through a 2-stage pipeline.
//   key_start/key_sin/key_sin_valid  serial key load, LSB first, parity bit last
//   key_o      key to datapath (key_o[i] -> p(i+1)); changes only when CHECK exits
//   key_ok     ARMED;  key_err  ERROR or LOCKED;  locked  LOCKED
//   in_*/out_* operand and result handshakes; dp_in/dp_out external datapath
//   dbg_state  current FSM state code (c499_lock_pkg ST_*)
module c499_lock_ctrl
  import c499_lock_pkg::*;
#(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int DIN_W    = DEF_DIN_W,
  parameter int DOUT_W   = DEF_DOUT_W,
  parameter int MAX_FAIL = DEF_MAX_FAIL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_start,
  input  logic              key_sin,
  input  logic              key_sin_valid,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_ok,
  output logic              key_err,
  output logic              locked,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  in_data,
  output logic [DIN_W-1:0]  dp_in,
  input  logic [DOUT_W-1:0] dp_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] out_data,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  state_t             state;
  logic [KEY_W-1:0]   shadow;
  logic [CNT_W-1:0]   cnt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic               par_bit;
  logic               pipe_empty;
  logic               par_match;

  assign par_match = (par_bit == even_parity(64'(shadow)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      key_o    <= '0;
      shadow   <= '0;
      cnt      <= '0;
      fail_cnt <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ARMED, ST_ERROR: begin
          // key_o is left alone: items already in the pipe keep the old key.
          if (key_start) begin
            state  <= ST_SHIFT;
            shadow <= '0;
            cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          if (key_start) begin
            shadow <= '0;
            cnt    <= '0;
          end else if (key_sin_valid) begin
            if (cnt == CNT_W'(KEY_W)) begin
              // The bit after the last key bit is the parity bit.
              par_bit <= key_sin;
              state   <= ST_CHECK;
            end else begin
              shadow[cnt] <= key_sin;
              cnt         <= cnt + CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          // Hold here until in-flight items have left, so key_o never changes
          // under an operand that was accepted with the previous key.
          if (pipe_empty) begin
            if (par_match) begin
              key_o    <= shadow;
              fail_cnt <= '0;
              state    <= ST_ARMED;
            end else begin
              key_o    <= '0;
              fail_cnt <= fail_cnt + FAIL_W'(1);
              if ((fail_cnt + FAIL_W'(1)) >= FAIL_W'(MAX_FAIL)) state <= ST_LOCKED;
              else                                              state <= ST_ERROR;
            end
          end
        end
        ST_LOCKED: begin
          key_o <= '0;
        end
        default: begin
          state <= ST_IDLE;
          key_o <= '0;
        end
      endcase
    end
  end

  assign key_ok    = (state == ST_ARMED);
  assign key_err   = (state == ST_ERROR) || (state == ST_LOCKED);
  assign locked    = (state == ST_LOCKED);
  assign dbg_state = state;

  c499_pipe2 #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (key_ok),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dp_in     (dp_in),
    .dp_out    (dp_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .empty     (pipe_empty)
  );

endmodule

// File: tb/tb_c499_lock_ctrl.sv
// tb_c499_lock_ctrl: bench for c499_lock_ctrl. A stand-in datapath turns dp_in and
// key_o into dp_out; the driver pushes the expected result for each accepted operand
// (using the key the bench believes is armed) and a negedge monitor pops and compares.
module tb_c499_lock_ctrl;
  import c499_lock_pkg::*;

  localparam int KW = 28;
  localparam int DW = 41;
  localparam int OW = 32;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_start, key_sin, key_sin_valid;
  logic [KW-1:0] key_o;
  logic          key_ok, key_err, locked;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data, dp_in;
  logic [OW-1:0] dp_out, out_data;
  logic          out_valid, out_ready;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  c499_lock_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_start     (key_start),
    .key_sin       (key_sin),
    .key_sin_valid (key_sin_valid),
    .key_o         (key_o),
    .key_ok        (key_ok),
    .key_err       (key_err),
    .locked        (locked),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .dp_in         (dp_in),
    .dp_out        (dp_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .dbg_state     (dbg_state)
  );

  // Stand-in for the c499 datapath: low operand bits, folded top bits, key-dependent mask.
  function automatic logic [OW-1:0] dp_fn(input logic [DW-1:0] d, input logic [KW-1:0] k);
    return d[31:0] ^ {k, k[3:0]} ^ {23'd0, d[40:32]};
  endfunction

  assign dp_out = dp_fn(dp_in, key_o);

  // ---------------- scoreboard and reference state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [OW-1:0] exp_q[$];
  logic [KW-1:0] model_key  = '0;
  int            model_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // Monitor: pops on every result handshake and checks that a stalled result holds.
  logic          hold_prev = 1'b0;
  logic [OW-1:0] hold_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'(1'b1));
        check("hold_data", 64'(out_data), 64'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", 64'(out_data), 64'(exp_q.pop_front()));
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  function automatic logic [DW-1:0] rand_op();
    return {9'($urandom_range(0, 511)), 32'($urandom)};
  endfunction

  // Leaves in_valid high on return so consecutive calls stream one per cycle.
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("send_timeout");
    else exp_q.push_back(dp_fn(d, model_key));
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    key_start = 1'b1;
    @(posedge clk); #1;
    key_start = 1'b0;
  endtask

  // Shifts the first nbits of {parity, key}; bad flips the parity bit.
  task automatic shift_bits(input logic [KW-1:0] key, input bit bad_par, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        key_sin_valid = 1'b0;
        key_sin       = 1'($urandom);
        @(posedge clk); #1;
      end
      key_sin_valid = 1'b1;
      key_sin       = (i < KW) ? key[i] : ((^key) ^ bad_par);
      @(posedge clk); #1;
    end
    key_sin_valid = 1'b0;
  endtask

  task automatic wait_check_exit();
    int n = 0;
    while (!(key_ok || key_err) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(key_ok || key_err)) fail_now("check_exit_timeout");
  endtask

  // Applies the load rules to the model and compares the status outputs.
  task automatic finish_load(input logic [KW-1:0] key, input bit bad_par);
    wait_check_exit();
    if (!bad_par) begin
      model_key  = key;
      model_fail = 0;
    end else begin
      model_key  = '0;
      model_fail++;
    end
    @(negedge clk);
    check("key_o", 64'(key_o), 64'(model_key));
    check("key_ok", 64'(key_ok), 64'(!bad_par));
    check("key_err", 64'(key_err), 64'(bad_par));
    check("locked", 64'(locked), 64'(model_fail >= DEF_MAX_FAIL));
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [KW-1:0] key, input bit bad_par);
    pulse_start();
    shift_bits(key, bad_par, KW + 1);
    finish_load(key, bad_par);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_o"}, 64'(key_o), 64'(0));
    check({tag, "_flags"}, 64'({key_ok, key_err, locked}), 64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    logic [KW-1:0] k2;
    bit done;

    rst_n = 1'b0; key_start = 0; key_sin = 0; key_sin_valid = 0;
    in_valid = 0; in_data = '0; out_ready = 0;
    #12;
    check_reset_outputs("reset");
    check("reset_dp_in", 64'(dp_in), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: good load of the reference key.
    load_key(28'h5A3CF01, 1'b0);

    // 2: latency of a lone item, then an 8-item stream at full rate.
    out_ready = 1'b1;
    send(rand_op());
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_edge2_out_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(rand_op());
    check("stream_cycles", 64'(cyc - t0), 64'(8));
    in_valid = 1'b0;
    drain();

    // 3: consumer stalls for 5 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op());
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_out_valid", 64'(out_valid), 64'(1));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random stream with a randomly toggling consumer.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(rand_op());
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // 4: reload while two items are in flight; key_start shares an edge with an accept.
    out_ready = 1'b0;
    send(rand_op());
    in_data   = rand_op();
    key_start = 1'b1;
    @(negedge clk);
    check("simul_in_ready", 64'(in_ready), 64'(1));
    if (in_ready) exp_q.push_back(dp_fn(in_data, model_key));
    @(posedge clk); #1;
    key_start = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("simul_ready_drop", 64'(in_ready), 64'(0));
    check("simul_state", 64'(dbg_state), 64'(ST_SHIFT));
    @(posedge clk); #1;
    k2 = 28'($urandom);
    shift_bits(k2, 1'b0, KW + 1);
    repeat (4) @(negedge clk);
    check("check_stall_state", 64'(dbg_state), 64'(ST_CHECK));
    check("check_stall_key_o", 64'(key_o), 64'(model_key));
    check("check_stall_items", 64'(exp_q.size()), 64'(2));
    @(posedge clk); #1;
    out_ready = 1'b1;
    finish_load(k2, 1'b0);
    check("drained_with_old_key", 64'(exp_q.size()), 64'(0));

    // 5: fail count clears on success, then three bad loads lock the block.
    load_key(28'($urandom), 1'b1);
    load_key(28'($urandom), 1'b1);
    load_key(28'($urandom), 1'b0);
    send(rand_op());
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) load_key(28'($urandom), 1'b1);
    pulse_start();
    key_sin_valid = 1'b1;
    key_sin       = 1'b1;
    repeat (3) @(negedge clk);
    check("locked_ignores_start", 64'(dbg_state), 64'(ST_LOCKED));
    check("locked_key_o", 64'(key_o), 64'(0));
    check("locked_in_ready", 64'(in_ready), 64'(0));
    key_sin_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_fail = 0;
    model_key  = '0;
    #1;
    check_reset_outputs("unlock_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 6: reset during SHIFT at bit 13 with an item still in the pipe.
    load_key(28'($urandom), 1'b0);
    out_ready = 1'b0;
    send(rand_op());
    in_valid = 1'b0;
    pulse_start();
    shift_bits(28'($urandom), 1'b0, 13);
    #3 rst_n = 1'b0;
    exp_q.delete();
    model_key = '0;
    #1;
    check_reset_outputs("mid_shift_reset");
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("no_delivery_after_reset", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    load_key(28'h5A3CF01, 1'b0);
    for (int i = 0; i < 4; i++) send(rand_op());
    in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
